// File: rtl/prefetch_queue_pkg.sv
// Shared sizing and types for the instruction prefetch queue and its byte FIFO.
package prefetch_queue_pkg;

   localparam int DEPTH = 6;
   localparam int AW    = 6;
   localparam int DW    = 8;
   localparam int CW    = 3;
   localparam int PW    = 3;

   typedef logic [DW-1:0] byte_t;
   typedef logic [AW-1:0] addr_t;
   typedef logic [CW-1:0] count_t;
   typedef logic [PW-1:0] ptr_t;

   // Queue pointers wrap at DEPTH, which is not a power of two.
   function automatic ptr_t ptrInc(input ptr_t p);
      return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
   endfunction

endpackage

// File: rtl/prefetch_queue_if.sv
// RAM read port plus decoder-side queue handshake of the prefetch stage.
interface prefetch_queue_if;
   import prefetch_queue_pkg::*;

   addr_t  mem_addr;
   byte_t  mem_rdata;
   logic   mem_req;
   logic   bus_busy;
   logic   flush;
   addr_t  flush_addr;
   byte_t  q_data;
   logic   q_valid;
   logic   q_pop;
   count_t q_count;

   modport slave (
      output mem_addr, mem_req, q_data, q_valid, q_count,
      input  mem_rdata, bus_busy, flush, flush_addr, q_pop
   );

   modport master (
      input  mem_addr, mem_req, q_data, q_valid, q_count,
      output mem_rdata, bus_busy, flush, flush_addr, q_pop
   );

endinterface

// File: rtl/prefetch_queue_fifo.sv
// Circular DEPTH-entry byte buffer with show-ahead head, occupancy count and synchronous clear.
module prefetch_fifo
   import prefetch_queue_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   clear_i,
   input  logic   push_i,
   input  logic   pop_i,
   input  byte_t  wdata_i,
   output byte_t  rdata_o,
   output count_t count_o,
   output logic   full_o,
   output logic   empty_o
);

   byte_t  mem_q [DEPTH];
   ptr_t   wptr_q, wptr_d;
   ptr_t   rptr_q, rptr_d;
   count_t count_q, count_d;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (clear_i) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (push_i) wptr_d = ptrInc(wptr_q);
         if (pop_i)  rptr_d = ptrInc(rptr_q);
         if (push_i && !pop_i)      count_d = count_q + count_t'(1);
         else if (pop_i && !push_i) count_d = count_q - count_t'(1);
      end
   end

   // When full, push and pop share one slot: the head is read out this cycle and overwritten at the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         if (push_i && !clear_i) mem_q[wptr_q] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[rptr_q];
   assign count_o = count_q;
   assign full_o  = (count_q == count_t'(DEPTH));
   assign empty_o = (count_q == '0);

endmodule

// File: rtl/prefetch_queue.sv
// Instruction prefetch stage: fetches sequential code bytes from RAM into a byte queue for the decoder.
module prefetch_queue
   import prefetch_queue_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   prefetch_queue_if.slave  pq_if
);

   addr_t  fetch_ptr_q, fetch_ptr_d;
   logic   popEff;
   logic   fetch;
   logic   full;
   logic   empty;
   count_t count;
   byte_t  head;

   // Flush wins over both pop and fetch; a full queue may still fetch when the head leaves this cycle.
   assign popEff = pq_if.q_pop & ~empty & ~pq_if.flush;
   assign fetch  = ~rst & ~pq_if.flush & ~pq_if.bus_busy & (~full | popEff);

   always_comb begin
      fetch_ptr_d = fetch_ptr_q;
      if (pq_if.flush)  fetch_ptr_d = pq_if.flush_addr;
      else if (fetch)   fetch_ptr_d = fetch_ptr_q + addr_t'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) fetch_ptr_q <= '0;
      else     fetch_ptr_q <= fetch_ptr_d;
   end

   prefetch_fifo u_fifo (
      .clk     (clk),
      .rst     (rst),
      .clear_i (pq_if.flush),
      .push_i  (fetch),
      .pop_i   (popEff),
      .wdata_i (pq_if.mem_rdata),
      .rdata_o (head),
      .count_o (count),
      .full_o  (full),
      .empty_o (empty)
   );

   assign pq_if.mem_addr = fetch_ptr_q;
   assign pq_if.mem_req  = fetch;
   assign pq_if.q_data   = head;
   assign pq_if.q_valid  = ~empty;
   assign pq_if.q_count  = count;

endmodule

// File: tb/tb_prefetch_queue.sv
// Randomized scoreboard bench for prefetch_queue against a queue-based reference model.
module tb_prefetch_queue;
   import prefetch_queue_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;

   prefetch_queue_if pqIf ();

   prefetch_queue dut (
      .clk   (clk),
      .rst   (rst),
      .pq_if (pqIf)
   );

   always #5 clk = ~clk;

   byte_t ram [64];
   assign pqIf.mem_rdata = ram[pqIf.mem_addr];

   int    testsRun    = 0;
   int    testsFailed = 0;
   byte_t expQ [$];
   int    modelAddr   = 0;
   bit    modelKnown  = 1'b0;

   task automatic compare(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
      end
   endtask

   // Runs mid-cycle after inputs settle: checks the DUT against the model, then advances the model.
   task automatic checkOutput();
      int cnt;
      bit popEff;
      bit req;
      cnt    = expQ.size();
      popEff = pqIf.q_pop && (cnt > 0) && !pqIf.flush;
      req    = !rst && !pqIf.flush && !pqIf.bus_busy && ((cnt < DEPTH) || popEff);
      if (modelKnown) begin
         compare("q_count",  32'(pqIf.q_count), 32'(cnt));
         compare("q_valid",  32'(pqIf.q_valid), 32'(cnt > 0));
         compare("mem_addr", 32'(pqIf.mem_addr), 32'(modelAddr));
         compare("mem_req",  32'(pqIf.mem_req), 32'(req));
         if (cnt > 0) compare("q_data_head", 32'(pqIf.q_data), 32'(expQ[0]));
      end else if (rst) begin
         compare("mem_req_in_reset", 32'(pqIf.mem_req), 32'(0));
      end
      if (rst) begin
         expQ.delete();
         modelAddr  = 0;
         modelKnown = 1'b1;
      end else if (modelKnown) begin
         if (pqIf.flush) begin
            expQ.delete();
            modelAddr = int'(pqIf.flush_addr);
         end else if (req) begin
            expQ.push_back(ram[modelAddr]);
            modelAddr = (modelAddr + 1) % 64;
         end
      end
   endtask

   task automatic applyStimulus(input logic r, input logic f, input addr_t fa, input logic busy, input logic pop);
      @(posedge clk);
      #2;
      rst             = r;
      pqIf.flush      = f;
      pqIf.flush_addr = fa;
      pqIf.bus_busy   = busy;
      pqIf.q_pop      = pop;
      #1;
      checkOutput();
   endtask

   // Monitor: every accepted pop must deliver the oldest byte the model has queued.
   always @(negedge clk) begin
      if (modelKnown && !rst && !pqIf.flush && pqIf.q_pop && pqIf.q_valid) begin
         if (expQ.size() == 0) begin
            compare("pop_on_model_empty", 32'(pqIf.q_valid), 32'(0));
         end else begin
            compare("q_data_pop", 32'(pqIf.q_data), 32'(expQ.pop_front()));
         end
      end
   end

   initial begin
      pqIf.flush      = 1'b0;
      pqIf.flush_addr = '0;
      pqIf.bus_busy   = 1'b0;
      pqIf.q_pop      = 1'b0;
      for (int i = 0; i < 64; i++) ram[i] = byte_t'($urandom_range(0, 255));
      for (int i = 0; i < 8; i++)  ram[i] = byte_t'(8'h10 + i);
      ram[6'h3E] = 8'hAA;
      ram[6'h3F] = 8'hBB;

      applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b1, 6'h3E, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 6'h20, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);

      for (int i = 0; i < 2000; i++) begin
         int popBias;
         popBias = (i / 200) % 3;
         applyStimulus(($urandom_range(0, 149) == 0),
                       ($urandom_range(0, 11) == 0),
                       addr_t'($urandom_range(0, 63)),
                       ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 3) < popBias + 1));
      end

      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
      @(posedge clk);
      #2;
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
